fnorm_pack: RTL

FNORM_PACK -- requirements
Module: fnorm_pack

---
 rtl/fnorm_pack.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fnorm_pack.sv
`default_nettype none
// ============================================================================
// Module      : fnorm_pack
// Description : Post add/sub normaliser and IEEE-754 single packer. Accepts
//               a raw 25-bit add/sub result with its common biased exponent,
//               resolves sign and magnitude, normalises it and packs it into
//               a 32-bit single with overflow / underflow (flush) flags.
//               Handshake: in_valid/in_ready upstream, out_valid/out_ready
//               downstream. One operation in flight at a time.
// Ports       : clk, rst_n (async, active low)
//               in_valid, in_ready, mant_in[24:0], exp_in[7:0],
//               s1_in, s2_in, sub_in
//               res[31:0], ovf, uf, out_valid, out_ready
// Config      : FNORM_FAST_SHIFT_EN - when defined, the whole left shift is
//               done in one edge using a leading-zero count; otherwise the
//               mantissa is shifted left one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fnorm_pack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [24:0] mant_in,
   input  logic [7:0]  exp_in,
   input  logic        s1_in,
   input  logic        s2_in,
   input  logic        sub_in,
   output logic [31:0] res,
   output logic        ovf,
   output logic        uf,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_NORM = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] C_EXP_MAX = 8'hFF;
   localparam logic [7:0] C_EXP_TOP = 8'hFE;

   state_t      r_state;
   logic [24:0] r_mag;
   logic [7:0]  r_exp;
   logic        r_sign;
   logic        r_in_ready;
   logic        r_out_valid;
   logic [31:0] r_res;
   logic        r_ovf;
   logic        r_uf;

   // A subtract that went negative carries the sign of operand B and needs
   // its magnitude recovered by two's complement negation.
   logic        w_neg;
   logic [24:0] w_acc_mag;
   logic        w_acc_sign;

   assign w_neg      = sub_in & mant_in[24];
   assign w_acc_mag  = w_neg ? (~mant_in + 25'd1) : mant_in;
   assign w_acc_sign = w_neg ? s2_in : s1_in;

`ifdef FNORM_FAST_SHIFT_EN
   // Leading zeros above the hidden-bit position (bit 23). Only consulted
   // when r_mag is non-zero and bits 24/23 are clear, so the range is 1..23.
   logic [4:0]  w_lzc;
   logic [22:0] w_mant_norm;
   logic        w_flush;

   always_comb begin
      w_lzc = 5'd24;
      for (int i = 0; i < 24; i++) begin
         if (r_mag[i]) begin
            w_lzc = 5'(23 - i);
         end
      end
   end

   // Bits 24:23 of r_mag are zero here, so shifting the low 23 bits alone
   // yields the packed fraction field.
   assign w_mant_norm = r_mag[22:0] << w_lzc;
   // The iterative shifter only decrements while exp > 1, so it runs out of
   // exponent exactly when the shift distance reaches the exponent.
   assign w_flush     = ({3'b000, w_lzc} >= r_exp);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mag       <= '0;
         r_exp       <= '0;
         r_sign      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_res       <= '0;
         r_ovf       <= 1'b0;
         r_uf        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mag      <= w_acc_mag;
                  r_exp      <= exp_in;
                  r_sign     <= w_acc_sign;
                  r_in_ready <= 1'b0;
                  r_state    <= S_NORM;
               end
            end

            S_NORM: begin
               if (r_exp == C_EXP_MAX) begin
                  r_res       <= {r_sign, C_EXP_MAX, 23'h0};
                  r_ovf       <= 1'b1;
                  r_uf        <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_mag == '0) begin
                  r_res       <= '0;
                  r_ovf       <= 1'b0;
                  r_uf        <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_mag[24]) begin
                  // Carry out of the add: one right shift always normalises.
                  if (r_exp == C_EXP_TOP) begin
                     r_res <= {r_sign, C_EXP_MAX, 23'h0};
                     r_ovf <= 1'b1;
                  end else begin
                     r_res <= {r_sign, 8'(r_exp + 8'd1), r_mag[23:1]};
                     r_ovf <= 1'b0;
                  end
                  r_uf        <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_mag[23]) begin
                  r_res       <= {r_sign, r_exp, r_mag[22:0]};
                  r_ovf       <= 1'b0;
                  r_uf        <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
`ifdef FNORM_FAST_SHIFT_EN
                  if (w_flush) begin
                     r_res <= '0;
                     r_uf  <= 1'b1;
                  end else begin
                     r_res <= {r_sign, 8'(r_exp - {3'b000, w_lzc}), w_mant_norm};
                     r_uf  <= 1'b0;
                  end
                  r_ovf       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
`else
                  if (r_exp > 8'd1) begin
                     r_mag <= {r_mag[23:0], 1'b0};
                     r_exp <= r_exp - 8'd1;
                  end else begin
                     // Out of exponent range before normalising: flush to +0.
                     r_res       <= '0;
                     r_ovf       <= 1'b0;
                     r_uf        <= 1'b1;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
`endif
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign res       = r_res;
   assign ovf       = r_ovf;
   assign uf        = r_uf;

endmodule
`default_nettype wire
